// File: rtl/pic_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pic_seq_pkg
//  Description : Shared types for the instruction phase sequencer. Defines the
//                sequencer state (HALTED/RUN/STEP), the Q1..Q4 phase index and
//                small helpers for phase decode and advance.
//  Revision    : 1.0 - initial release
// ============================================================================
package pic_seq_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_Q1 = 2'd0,
    PH_Q2 = 2'd1,
    PH_Q3 = 2'd2,
    PH_Q4 = 2'd3
  } phase_e;

  // One-hot enable for a phase: Q1 -> bit0 ... Q4 -> bit3.
  function automatic logic [3:0] phase_onehot(input phase_e ph);
    return 4'b0001 << ph;
  endfunction

  // Q4 rolls over to Q1 through natural 2-bit wrap.
  function automatic phase_e phase_next(input phase_e ph);
    logic [1:0] v;
    v = ph;
    v = v + 2'd1;
    return phase_e'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_counter
//  Description : Wrapping counter of completed instruction cycles.
//  Ports       : clk     - system clock
//                clr_i   - synchronous clear (has priority over enable)
//                en_i    - count enable, one increment per enabled clock
//                count_o - current count, wraps from all-ones to zero
//  Revision    : 1.0 - initial release
// ============================================================================
module cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer
//  Description : Four-phase (Q1..Q4) instruction-cycle sequencer with
//                free-run, halt-at-boundary, single-step, stall and flush.
//  Ports       : clk         - system clock, rising edge
//                reset       - synchronous active-high reset
//                run         - 1 = free-run, 0 = halt at next Q4 boundary
//                step_req    - pulse: one instruction cycle while halted
//                stall_req   - level: freeze phase progression
//                flush_req   - sampled on unstalled Q4: next cycle is a NOP
//                q_en        - one-hot phase enables, zero when not advancing
//                nop_cycle   - high throughout a flushed cycle
//                inst_done   - high with the Q4 enable
//                halted      - high while halted
//                cycle_count - completed instruction cycles (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer
  import pic_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_req,
  input  logic             stall_req,
  input  logic             flush_req,
  output logic [3:0]       q_en,
  output logic             nop_cycle,
  output logic             inst_done,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  seq_state_e state_q, state_d;
  phase_e     phase_q, phase_d;
  // Marks the cycle starting at the next Q1 as a NOP; it is rewritten on
  // every unstalled Q4 and simply holds while halted, so a flush survives
  // a halt and lands on the next executed cycle.
  logic       nop_q, nop_d;

  logic       advance;
  logic       q4_done;

  assign advance = (state_q != ST_HALTED) && !stall_req;
  // run and flush_req are only meaningful on this qualifier, so a stalled
  // Q4 never samples them.
  assign q4_done = advance && (phase_q == PH_Q4);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    nop_d   = nop_q;

    case (state_q)
      ST_HALTED: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (q4_done && !run) begin
          state_d = ST_HALTED;
        end
      end
      ST_STEP: begin
        if (q4_done) begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_HALTED;
    endcase

    // Halting only happens after Q4, so the wrap leaves phase at Q1.
    if (advance) begin
      phase_d = phase_next(phase_q);
    end

    if (q4_done) begin
      nop_d = flush_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HALTED;
      phase_q <= PH_Q1;
      nop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      nop_q   <= nop_d;
    end
  end

  cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk     (clk),
    .clr_i   (reset),
    .en_i    (q4_done),
    .count_o (cycle_count)
  );

  assign q_en      = advance ? phase_onehot(phase_q) : 4'b0000;
  assign inst_done = q_en[3];
  assign halted    = (state_q == ST_HALTED);
  assign nop_cycle = !halted && nop_q;

endmodule
`default_nettype wire

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the instruction-cycle counter.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port run, input, 1: 1 = free-run, 0 = halt at the next instruction boundary.
REQ-005 SHALL have port step_req, input, 1: single-cycle pulse requesting one instruction cycle while halted.
REQ-006 SHALL have port stall_req, input, 1: level; freezes phase progression while high.
REQ-007 SHALL have port flush_req, input, 1: sampled in Q4; the next instruction cycle becomes a NOP.
REQ-008 SHALL have port q_en, output, 4: one-hot phase enables, bit0 = Q1 through bit3 = Q4; all-zero when not advancing.
REQ-009 SHALL have port nop_cycle, output, 1: high during all four phases of a flushed cycle.
REQ-010 SHALL have port inst_done, output, 1: high in the clock where Q4 is asserted.
REQ-011 SHALL have port halted, output, 1: high while in HALTED.
REQ-012 SHALL have port cycle_count, output, CNT_W: completed instruction cycles.

Function
REQ-013 SHALL implement states HALTED, RUN and STEP; the phase index is 2 bits (Q1..Q4).
REQ-014 In RUN or STEP with stall_req=0, SHALL assert exactly one q_en bit per clock, in order Q1,Q2,Q3,Q4,Q1...
REQ-015 With stall_req=1, SHALL drive q_en=0 and hold the phase index; resumes at the held phase on the first clock with stall_req=0.
REQ-016 HALTED -> RUN when run=1; the first enabled phase is Q1 on the next clock.
REQ-017 HALTED -> STEP on step_req=1 with run=0; executes exactly Q1..Q4 (stalls honoured), then returns to HALTED.
REQ-018 RUN -> HALTED only at the boundary: when run=0 is sampled during an unstalled Q4 clock, that Q4 completes and the next clock is HALTED.
REQ-019 SHALL ignore step_req while in RUN or STEP.
REQ-020 SHALL latch flush_req=1 on an unstalled Q4 clock; nop_cycle=1 for the next executed Q1..Q4, including across a halt.
REQ-021 SHALL increment cycle_count on every unstalled Q4 clock, NOP cycles included, wrapping from all-ones to 0.
REQ-022 inst_done SHALL equal q_en[3].
REQ-023 On a stalled Q4 clock, SHALL sample neither run nor flush_req; they are evaluated on the unstalled Q4.
REQ-024 When flush and halt fall in the same Q4, SHALL enter HALTED with the flush pending; nop_cycle applies to the next executed cycle.

Reset
REQ-025 On reset=1 at a clock edge, SHALL go to HALTED, phase Q1, flush pending cleared and cycle_count=0, regardless of current phase or stall.
REQ-026 During and after reset, SHALL drive q_en=0, nop_cycle=0, inst_done=0 and halted=1 until a run or step is accepted.

Structure
REQ-027 SHALL place the state enumeration (HALTED/RUN/STEP) and the phase enumeration (Q1..Q4) in shared package pic_seq_pkg.
REQ-028 SHALL implement the wrapping cycle counter as sub-module cycle_counter (enable, clear, CNT_W-wide count).

Verification
REQ-029 Reset, then run=1 held: q_en = 0001,0010,0100,1000,0001 on clocks 1..5; cycle_count=1 after clock 4.
REQ-030 stall_req=1 for 3 clocks starting in Q2: q_en=0 for 3 clocks, then Q2 resumes; cycle_count unchanged until that Q4.
REQ-031 run dropped in Q2: Q3 and Q4 still issue, then halted=1 and q_en=0; a step_req pulse gives exactly one Q1..Q4, then halted=1.
REQ-032 flush_req=1 in Q4 together with run=0: halts; the next step gives nop_cycle=1 for 4 clocks; a second step gives nop_cycle=0.
REQ-033 CNT_W=4: 16 cycles wrap cycle_count 15->0; reset asserted in Q3 gives q_en=0, cycle_count=0 and halted=1 on the next edge.
